midi_tx_sequencer: RTL and testbench
====================================

// Module: midi_tx_sequencer
// PURPOSE
//  Queues complete MIDI messages (status + up to 2 data bytes) and serialises them
//  byte-by-byte into the uart_tx byte interface (valid pulse / ready level).
//  Derives message length from status, optionally applies running status, and
//  enforces an inter-byte gap. Sits between note/control logic and uart_tx.
// PARAMETERS
//  DEPTH          4   message FIFO entries; power of two, >=2
//  GAP_CYCLES     20  idle clk cycles after tx_ready returns high, before next byte
//  RUNNING_STATUS 0   1 = omit status byte when equal to last sent channel status
// PORTS
//  clk         in  1  system clock, all logic rising-edge
//  reset_n     in  1  asynchronous active-low reset
//  msg_valid   in  1  message offered
//  msg_ready   out 1  FIFO can accept; transfer on msg_valid & msg_ready
//  msg_status  in  8  status byte (bit7 must be 1)
//  msg_data1   in  7  first data byte payload
//  msg_data2   in  7  second data byte payload
//  tx_valid    out 1  one-cycle byte strobe to uart_tx
//  tx_ready    in  1  uart_tx idle (high = can accept byte)
//  tx_d_in     out 8  byte to uart_tx; held stable until next ISSUE
//  busy        out 1  FSM not IDLE or FIFO non-empty
//  err         out 1  one-cycle pulse: message rejected
//  fifo_level  out $clog2(DEPTH)+1  entries stored
// BEHAVIOUR
//  Reset: msg_ready=1, tx_valid=0, tx_d_in=8'h00, busy=0, err=0, fifo_level=0,
//   FIFO emptied, running-status register cleared (none valid), FSM -> IDLE.
//   Reset mid-byte abandons the message; no further tx_valid.
//  FIFO: msg_ready = !full. Accepted push with msg_status[7]==0 is not stored;
//   err pulses next cycle. Push and pop in same cycle allowed (level unchanged).
//  Length: 8x,9x,Ax,Bx,Ex -> 3 bytes; Cx,Dx -> 2; F0-FF -> 1 (data ignored).
//  Data bytes emitted with bit7 forced 0.
//  Running status (RUNNING_STATUS=1): 8x-Ex status skipped if equal to stored
//   value; every sent 8x-Ex status updates store; F0-F7 clears store;
//   F8-FF leave store unchanged.
//  FSM:
//   IDLE  : FIFO non-empty -> pop head into working regs, byte index 0 -> ISSUE.
//   ISSUE : wait tx_ready=1; then tx_valid=1 for exactly one cycle,
//           tx_d_in=current byte -> HOLD.
//   HOLD  : one cycle, tx_ready ignored (uart_tx latency) -> WAIT.
//   WAIT  : tx_ready=1 -> GAP (or straight to NEXT step if GAP_CYCLES=0).
//   GAP   : count GAP_CYCLES cycles; then more bytes -> ISSUE (index+1),
//           else -> IDLE.
//  Pop-to-first-tx_valid latency: 2 cycles when tx_ready already high.
//  New messages may be pushed in any state; order strictly FIFO.
//  tx_valid never asserted while tx_ready=0.
// TESTING
//  T1 push {91,30,01}, tx_ready idle -> bytes 91,30,01; each tx_valid one cycle,
//     >=GAP_CYCLES idle cycles after tx_ready re-high between bytes.
//  T2 RUNNING_STATUS=1: push {91,30,01} then {91,40,01} -> 91,30,01,40,01;
//     with RUNNING_STATUS=0 -> 91,30,01,91,40,01.
//  T3 push {C2,05,7F} -> C2,05 only; push {F8,..} between two 91 msgs with RS=1
//     -> F8 sent, second 91 still omitted; push {F0,..} -> following 91 re-sent.
//  T4 hold tx_ready=0, push DEPTH+1 msgs -> msg_ready=0 after DEPTH, fifo_level=DEPTH,
//     no tx_valid; release -> all DEPTH msgs sent in order.
//  T5 push {30,10,10} -> err one pulse, fifo_level stays 0, no tx_valid;
//     push {90,FF,FF} -> bytes 90,7F,7F.
//  T6 reset_n low while in WAIT of 2nd byte -> outputs at reset values
//     immediately, fifo_level=0; after release no tx_valid until new push.

Source files
------------

// File: rtl/midi_tx_sequencer.sv
// midi_tx_sequencer: queues complete MIDI messages and feeds them byte by byte
// into a uart_tx byte port, with length decode, optional running status and a
// programmable idle gap between bytes.
module midi_tx_sequencer #(
  parameter int DEPTH          = 4,
  parameter int GAP_CYCLES     = 20,
  parameter bit RUNNING_STATUS = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   msg_valid,
  output logic                   msg_ready,
  input  logic [7:0]             msg_status,
  input  logic [6:0]             msg_data1,
  input  logic [6:0]             msg_data2,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [7:0]             tx_d_in,
  output logic                   busy,
  output logic                   err,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef struct packed {
    logic [7:0] status;
    logic [6:0] data1;
    logic [6:0] data2;
  } msg_t;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_HOLD, S_WAIT, S_GAP} state_e;

  // Message FIFO
  msg_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] count_q;
  logic          err_q;
  logic          full, empty, push_acc, push, pop;
  msg_t          head;

  // Serialiser state
  state_e        state_q, state_d;
  msg_t          cur_q, cur_d;
  logic [1:0]    len_q, len_d;
  logic [1:0]    idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_d_q, tx_d_d;
  logic [7:0]    rs_q, rs_d;
  logic          rs_valid_q, rs_valid_d;

  logic [7:0]    cur_byte;
  logic          skip_status, more_bytes, gap_last;
  state_e        step_state;
  logic [1:0]    step_idx;

  // Message length implied by the status byte's high nibble.
  function automatic logic [1:0] msg_len(input logic [7:0] status);
    case (status[7:4])
      4'hC, 4'hD: msg_len = 2'd2;
      4'hF:       msg_len = 2'd1;
      default:    msg_len = 2'd3;
    endcase
  endfunction

  assign full     = (count_q == LW'(DEPTH));
  assign empty    = (count_q == '0);
  assign push_acc = msg_valid & ~full;
  assign push     = push_acc & msg_status[7];
  assign head     = mem_q[rd_ptr_q];

  // Write accepted, well-formed messages into the storage array.
  // NOTE: the storage array has no reset; count_q alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {msg_status, msg_data1, msg_data2};
  end

  // FIFO pointers, occupancy and the one-cycle reject strobe.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= push_acc & ~msg_status[7];
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: ;
      endcase
    end
  end

  // Select the byte addressed by idx_q; data bytes have bit7 cleared.
  always_comb begin
    case (idx_q)
      2'd0:    cur_byte = cur_q.status;
      2'd1:    cur_byte = {1'b0, cur_q.data1};
      default: cur_byte = {1'b0, cur_q.data2};
    endcase
  end

  // Running status: channel status equal to the last one sent is dropped.
  assign skip_status = RUNNING_STATUS && rs_valid_q &&
                       (head.status[7:4] != 4'hF) && (head.status == rs_q);
  assign more_bytes  = (idx_q + 2'd1) < len_q;
  assign step_state  = more_bytes ? S_ISSUE : S_IDLE;
  assign step_idx    = more_bytes ? idx_q + 2'd1 : idx_q;
  assign gap_last    = (int'(gap_q) == GAP_CYCLES - 1);

  // Serialiser next-state and datapath.
  // NOTE: every _d takes its _q value first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    len_d      = len_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    tx_valid_d = 1'b0;
    tx_d_d     = tx_d_q;
    rs_d       = rs_q;
    rs_valid_d = rs_valid_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          cur_d   = head;
          len_d   = msg_len(head.status);
          idx_d   = skip_status ? 2'd1 : 2'd0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (tx_ready) begin
          tx_valid_d = 1'b1;
          tx_d_d     = cur_byte;
          state_d    = S_HOLD;
          if (idx_q == 2'd0) begin
            if (cur_q.status[7:4] != 4'hF) begin
              rs_d       = cur_q.status;
              rs_valid_d = 1'b1;
            end else if (!cur_q.status[3]) begin
              rs_valid_d = 1'b0;  // system common F0-F7 cancels running status
            end
          end
        end
      end
      S_HOLD: state_d = S_WAIT;  // uart_tx needs a cycle to drop tx_ready
      S_WAIT: begin
        if (tx_ready) begin
          if (GAP_CYCLES == 0) begin
            state_d = step_state;
            idx_d   = step_idx;
          end else begin
            state_d = S_GAP;
            gap_d   = '0;
          end
        end
      end
      S_GAP: begin
        if (gap_last) begin
          state_d = step_state;
          idx_d   = step_idx;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Serialiser registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      gap_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_d_q     <= 8'h00;
      rs_q       <= 8'h00;
      rs_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      tx_valid_q <= tx_valid_d;
      tx_d_q     <= tx_d_d;
      rs_q       <= rs_d;
      rs_valid_q <= rs_valid_d;
    end
  end

  assign msg_ready  = ~full;
  assign tx_valid   = tx_valid_q;
  assign tx_d_in    = tx_d_q;
  assign busy       = (state_q != S_IDLE) | ~empty;
  assign err        = err_q;
  assign fifo_level = count_q;

endmodule

// File: tb/tb_midi_tx_sequencer.sv
// tb_midi_tx_sequencer: directed bench; dut uses running status, dut0 does not.
module tb_midi_tx_sequencer;

  localparam int GAP   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       msg_valid, msg_valid0;
  logic [7:0] msg_status;
  logic [6:0] msg_data1, msg_data2;
  logic       hold_low;

  logic       msg_ready, tx_valid, tx_ready, busy, err;
  logic [7:0] tx_d_in;
  logic [2:0] fifo_level;
  logic       msg_ready0, tx_valid0, tx_ready0, busy0, err0;
  logic [7:0] tx_d_in0;
  logic [2:0] fifo_level0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int busy_cnt, busy_cnt0;
  int last_rise = -1000;
  bit armed, prev_valid, prev_ready;

  logic [7:0] got_q[$], got0_q[$], exp_q[$], exp0_q[$];

  midi_tx_sequencer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .RUNNING_STATUS(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_status(msg_status), .msg_data1(msg_data1), .msg_data2(msg_data2),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_d_in(tx_d_in),
    .busy(busy), .err(err), .fifo_level(fifo_level));

  midi_tx_sequencer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .RUNNING_STATUS(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .msg_valid(msg_valid0), .msg_ready(msg_ready0),
    .msg_status(msg_status), .msg_data1(msg_data1), .msg_data2(msg_data2),
    .tx_valid(tx_valid0), .tx_ready(tx_ready0), .tx_d_in(tx_d_in0),
    .busy(busy0), .err(err0), .fifo_level(fifo_level0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx models: busy for 6 cycles after each accepted byte.
  always @(posedge clk or negedge reset_n)
    if (!reset_n)            busy_cnt <= 0;
    else if (tx_valid)       busy_cnt <= 6;
    else if (busy_cnt > 0)   busy_cnt <= busy_cnt - 1;
  assign tx_ready = ~hold_low & (busy_cnt == 0);

  always @(posedge clk or negedge reset_n)
    if (!reset_n)            busy_cnt0 <= 0;
    else if (tx_valid0)      busy_cnt0 <= 6;
    else if (busy_cnt0 > 0)  busy_cnt0 <= busy_cnt0 - 1;
  assign tx_ready0 = (busy_cnt0 == 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Byte capture plus protocol checks on the running-status instance.
  always @(negedge clk) begin
    if (!reset_n) begin
      armed      = 1'b0;
      prev_valid = 1'b0;
      prev_ready = 1'b1;
    end else begin
      if (tx_ready && !prev_ready && armed) begin
        last_rise = cyc;
        armed     = 1'b0;
      end
      if (tx_valid) begin
        got_q.push_back(tx_d_in);
        check("tx_ready_at_valid", tx_ready, 1);
        check("valid_one_cycle", prev_valid, 0);
        check("gap_after_ready", (cyc - last_rise) > GAP, 1);
        armed = 1'b1;
      end
      prev_valid = tx_valid;
      prev_ready = tx_ready;
    end
  end

  always @(negedge clk) if (reset_n && tx_valid0) got0_q.push_back(tx_d_in0);

  task automatic push(input bit sel, input logic [7:0] st, input logic [6:0] d1,
                      input logic [6:0] d2);
    int t = 0;
    @(negedge clk);
    while (!(sel ? msg_ready0 : msg_ready) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("push_ready", sel ? msg_ready0 : msg_ready, 1);
    msg_status = st;
    msg_data1  = d1;
    msg_data2  = d2;
    if (sel) msg_valid0 = 1'b1;
    else     msg_valid  = 1'b1;
    @(negedge clk);
    msg_valid  = 1'b0;
    msg_valid0 = 1'b0;
  endtask

  // Wait for the chosen instance to go idle, then compare captured bytes.
  task automatic compare_stream(input string tag, input bit sel);
    logic [7:0] g[$];
    logic [7:0] e[$];
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (((sel ? busy0 : busy) || !(sel ? tx_ready0 : tx_ready)) && t < 3000);
    repeat (2) @(negedge clk);
    #1;
    check({tag, "_done"}, t < 3000, 1);
    if (sel) begin g = got0_q; e = exp0_q; got0_q.delete(); exp0_q.delete(); end
    else     begin g = got_q;  e = exp_q;  got_q.delete();  exp_q.delete();  end
    check({tag, "_len"}, g.size(), e.size());
    for (int i = 0; i < g.size() && i < e.size(); i++)
      check($sformatf("%s_b%0d", tag, i), g[i], e[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset_n = 1'b0; msg_valid = 1'b0; msg_valid0 = 1'b0; hold_low = 1'b0;
    msg_status = 8'h00; msg_data1 = 7'h00; msg_data2 = 7'h00;
    repeat (3) @(negedge clk);
    check("rst_msg_ready", msg_ready, 1);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_d_in", tx_d_in, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst0_err", err0, 0);
    check("rst0_fifo_level", fifo_level0, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);

    // T1: single note-on, two-cycle pop-to-strobe latency
    push(0, 8'h91, 7'h30, 7'h01);
    check("t1_level_after_push", fifo_level, 1);
    @(negedge clk);
    check("t1_lat_cycle1", tx_valid, 0);
    @(negedge clk);
    check("t1_lat_cycle2", tx_valid, 1);
    check("t1_first_byte", tx_d_in, 8'h91);
    exp_q = '{8'h91, 8'h30, 8'h01};
    compare_stream("t1", 0);

    // T2: repeated status omitted with running status, re-sent without
    push(0, 8'h91, 7'h40, 7'h01);
    exp_q = '{8'h40, 8'h01};
    compare_stream("t2_rs1", 0);
    push(1, 8'h91, 7'h30, 7'h01);
    push(1, 8'h91, 7'h40, 7'h01);
    exp0_q = '{8'h91, 8'h30, 8'h01, 8'h91, 8'h40, 8'h01};
    compare_stream("t2_rs0", 1);

    // T3: two-byte message, realtime keeps store, system common clears it
    push(0, 8'hC2, 7'h05, 7'h7F);
    push(0, 8'h91, 7'h51, 7'h01);
    push(0, 8'hF8, 7'h11, 7'h22);
    push(0, 8'h91, 7'h50, 7'h02);
    push(0, 8'hF0, 7'h33, 7'h44);
    push(0, 8'h91, 7'h60, 7'h03);
    exp_q = '{8'hC2, 8'h05, 8'h91, 8'h51, 8'h01, 8'hF8,
              8'h50, 8'h02, 8'hF0, 8'h91, 8'h60, 8'h03};
    compare_stream("t3", 0);

    // T4: uart stalled; one message in the working regs, FIFO fills up
    hold_low = 1'b1;
    push(0, 8'h90, 7'h01, 7'h02);
    push(0, 8'h90, 7'h03, 7'h04);
    push(0, 8'hC5, 7'h06, 7'h7F);
    push(0, 8'hFE, 7'h01, 7'h01);
    push(0, 8'hB3, 7'h07, 7'h08);
    check("t4_level_full", fifo_level, DEPTH);
    check("t4_ready_low", msg_ready, 0);
    @(negedge clk);
    msg_status = 8'h90; msg_data1 = 7'h0A; msg_data2 = 7'h0B; msg_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("t4_level_held", fifo_level, DEPTH);
    check("t4_no_err", err, 0);
    msg_valid = 1'b0;
    check("t4_no_tx", got_q.size(), 0);
    hold_low = 1'b0;
    exp_q = '{8'h90, 8'h01, 8'h02, 8'h03, 8'h04, 8'hC5, 8'h06,
              8'hFE, 8'hB3, 8'h07, 8'h08};
    compare_stream("t4", 0);

    // T5: status without bit7 rejected, data bit7 forced low
    push(0, 8'h30, 7'h10, 7'h10);
    check("t5_err_pulse", err, 1);
    check("t5_level_zero", fifo_level, 0);
    @(negedge clk);
    check("t5_err_one_cycle", err, 0);
    push(0, 8'h90, 7'h7F, 7'h7F);
    exp_q = '{8'h90, 8'h7F, 8'h7F};
    compare_stream("t5", 0);

    // T6: reset while waiting after the second byte
    push(0, 8'h92, 7'h11, 7'h22);
    push(0, 8'h93, 7'h33, 7'h44);
    t = 0;
    while (got_q.size() < 2 && t < 500) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("t6_two_bytes_seen", t < 500, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t6_rst_msg_ready", msg_ready, 1);
    check("t6_rst_tx_valid", tx_valid, 0);
    check("t6_rst_tx_d_in", tx_d_in, 8'h00);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_err", err, 0);
    check("t6_rst_fifo_level", fifo_level, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("t6_no_tx_after_reset", got_q.size(), 2);
    check("t6_idle_after_reset", busy, 0);
    exp_q = '{8'h92, 8'h11};
    compare_stream("t6_partial", 0);
    push(0, 8'h92, 7'h01, 7'h02);
    exp_q = '{8'h92, 8'h01, 8'h02};
    compare_stream("t6_after", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
